pong_frame_ctrl: RTL and testbench
==================================

// Module: pong_frame_ctrl
// PURPOSE
//  Frame-synchronous update controller between the Nios position PIOs and the video renderer.
//  Nios software writes new ball/paddle coordinates, then raises upd_req.
//  The block stages those coordinates and commits them to renderer-facing shadow registers
//  only at vertical blanking, so a frame never mixes old and new positions.
//  It returns busy to the Nios PIO as a 4-phase handshake and falls back to a watchdog
//  commit if blanking never arrives.
// PARAMETERS
//  X_MAX    639    largest legal x coordinate; committed x values are clamped to it
//  Y_MAX    479    largest legal y coordinate; committed y values are clamped to it
//  TIMEOUT  50000  clk cycles waited for vblank before a forced commit (>=2)
//  CNT_W    16     width of the watchdog counter (2**CNT_W > TIMEOUT)
// PORTS
//  clk_clk        in   1   system clock, all logic on rising edge
//  reset_reset_n  in   1   asynchronous active-low reset
//  upd_req        in   1   Nios update request, level; held high until busy seen low after commit
//  vblank         in   1   one-cycle pulse at start of vertical blanking, clk_clk domain
//  bx_in,by_in    in   10  ball coordinates from Nios PIO
//  p1x_in,p1y_in  in   10  player-1 paddle coordinates from Nios PIO
//  p2x_in,p2y_in  in   10  player-2 paddle coordinates from Nios PIO
//  busy           out  1   to Nios busy PIO; high while an update is in flight
//  bx,by          out  10  committed ball coordinates to renderer
//  p1x,p1y        out  10  committed paddle-1 coordinates
//  p2x,p2y        out  10  committed paddle-2 coordinates
//  commit         out  1   one-cycle pulse; high in the first cycle new coordinates are visible
//  timeout        out  1   sticky; last commit was forced by watchdog
//  frame_cnt      out  8   number of commits since reset, wraps 255->0
// BEHAVIOUR
//  Reset (async, reset_reset_n=0)
//   - state=IDLE; all coordinate outputs, staging registers and watchdog cleared to 0.
//   - busy=0, commit=0, timeout=0, frame_cnt=0.
//   - Reset mid-update discards staged data; shadows return to 0.
//  Outputs
//   - busy=1 in WAIT_VB, COMMIT and ACK_WAIT; busy=0 in IDLE.
//   - commit=1 only in COMMIT. All outputs decode from registered state.
//  IDLE
//   - upd_req=1 at an edge: all six *_in values are staged, watchdog=0, timeout=0, state->WAIT_VB.
//   - vblank is ignored in IDLE.
//  WAIT_VB
//   - vblank=1 at an edge -> COMMIT; a vblank in the first WAIT_VB cycle counts.
//   - Otherwise watchdog++. When watchdog==TIMEOUT-1 at an edge (no vblank), also ->COMMIT
//     and set timeout=1.
//   - vblank and the timeout in the same cycle: normal commit, timeout stays 0.
//   - *_in changes after capture are ignored.
//  Transition into COMMIT (same edge)
//   - Shadows load the staged values. Each x is min(staged,X_MAX); each y is min(staged,Y_MAX),
//     as an unsigned 10-bit compare.
//   - frame_cnt+1, mod 256.
//  COMMIT
//   - Lasts exactly one cycle, then ->ACK_WAIT unconditionally.
//  ACK_WAIT
//   - upd_req=0 at an edge -> IDLE, so busy falls on the next cycle.
//   - While upd_req stays 1, remain in ACK_WAIT. There are no back-to-back updates without
//     upd_req first dropping.
//  Latency
//   - Request seen at edge N gives busy=1 after N.
//   - vblank seen at edge M gives new coordinates and commit=1 after M.
//   - Minimum request-to-commit is 2 edges.
//  Shadows hold their value between commits; the renderer may sample them at any time.
// TESTING
//  1. Reset, then check outputs: all coordinates 0, busy=0, frame_cnt=0, timeout=0.
//  2. Nominal update:
//     - Stimulus: set bx=100, by=200, p1x=10, p1y=50, p2x=600, p2y=70; upd_req=1;
//       vblank 5 cycles later.
//     - Required: busy=1 from the cycle after req. Values appear with commit pulsed one cycle
//       after vblank. frame_cnt=1. busy drops one cycle after upd_req=0.
//  3. Clamp: commit bx=700, by=500, p2x=1023 -> bx=639, by=479, p2x=639, others unchanged.
//  4. Watchdog: run with TIMEOUT=8, upd_req=1 and no vblank.
//     - Required: commit at the 8th WAIT_VB edge and timeout=1.
//     - Next request clears timeout on capture.
//  5. Ignored events:
//     - vblank in IDLE: no commit.
//     - *_in changed after capture: old values committed.
//     - Second vblank while in ACK_WAIT: no second commit.
//  6. Reset in WAIT_VB with bx=300 staged: outputs stay 0, busy=0. 256 commits wrap frame_cnt to 0.

Source files
------------

// File: rtl/pong_frame_ctrl.sv
// Frame-synchronous coordinate update controller: stages Nios-written positions and
// commits them to renderer shadows at vblank, with a watchdog-forced fallback commit.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no update in flight, busy low, waiting for upd_req
// WAIT_VB  | coordinates staged, waiting for vblank or watchdog expiry
// COMMIT   | single cycle, shadows just loaded, commit pulse high
// ACK_WAIT | update done, waiting for Nios to drop upd_req
module pong_frame_ctrl #(
  parameter int X_MAX   = 639,
  parameter int Y_MAX   = 479,
  parameter int TIMEOUT = 50000,
  parameter int CNT_W   = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       upd_req,
  input  logic       vblank,
  input  logic [9:0] bx_in,
  input  logic [9:0] by_in,
  input  logic [9:0] p1x_in,
  input  logic [9:0] p1y_in,
  input  logic [9:0] p2x_in,
  input  logic [9:0] p2y_in,
  output logic       busy,
  output logic [9:0] bx,
  output logic [9:0] by,
  output logic [9:0] p1x,
  output logic [9:0] p1y,
  output logic [9:0] p2x,
  output logic [9:0] p2y,
  output logic       commit,
  output logic       timeout,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0]       X_LIM   = 10'(X_MAX);
  localparam logic [9:0]       Y_LIM   = 10'(Y_MAX);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VB, COMMIT, ACK_WAIT} state_t;

  state_t             state_q, state_d;
  // Packed slot order: bx, by, p1x, p1y, p2x, p2y (even = x, odd = y)
  logic [5:0][9:0]    stg_q, stg_d;
  logic [5:0][9:0]    sh_q, sh_d;
  logic [CNT_W-1:0]   wd_q, wd_d;
  logic               to_q, to_d;
  logic [7:0]         fc_q, fc_d;
  logic               do_commit;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      stg_q   <= '0;
      sh_q    <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
      sh_q    <= sh_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stg_d     = stg_q;
    sh_d      = sh_q;
    wd_d      = wd_q;
    to_d      = to_q;
    fc_d      = fc_q;
    do_commit = 1'b0;

    case (state_q)
      IDLE: begin
        if (upd_req) begin
          stg_d   = {p2y_in, p2x_in, p1y_in, p1x_in, by_in, bx_in};
          wd_d    = '0;
          to_d    = 1'b0;
          state_d = WAIT_VB;
        end
      end
      WAIT_VB: begin
        // vblank wins over a coinciding watchdog expiry
        if (vblank) begin
          do_commit = 1'b1;
        end else if (wd_q == WD_LAST) begin
          do_commit = 1'b1;
          to_d      = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      COMMIT: begin
        state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (!upd_req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_commit) begin
      state_d = COMMIT;
      fc_d    = fc_q + 8'd1;
      for (int i = 0; i < 3; i++) begin
        sh_d[2*i]   = (stg_q[2*i]   > X_LIM) ? X_LIM : stg_q[2*i];
        sh_d[2*i+1] = (stg_q[2*i+1] > Y_LIM) ? Y_LIM : stg_q[2*i+1];
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign commit    = (state_q == COMMIT);
  assign timeout   = to_q;
  assign frame_cnt = fc_q;
  assign bx        = sh_q[0];
  assign by        = sh_q[1];
  assign p1x       = sh_q[2];
  assign p1y       = sh_q[3];
  assign p2x       = sh_q[4];
  assign p2y       = sh_q[5];

endmodule

// File: tb/tb_pong_frame_ctrl.sv
// Self-checking bench for pong_frame_ctrl: transaction-level model predicts commit edge,
// clamped shadows, frame count and timeout flag for directed and random updates.
module tb_pong_frame_ctrl;

  localparam int X_MAX = 639;
  localparam int Y_MAX = 479;
  localparam int TO    = 8;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       upd_req;
  logic       vblank;
  logic [9:0] bx_in, by_in, p1x_in, p1y_in, p2x_in, p2y_in;
  logic       busy, commit, timeout;
  logic [9:0] bx, by, p1x, p1y, p2x, p2y;
  logic [7:0] frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int  m_sh[6];
  int  m_fc;
  bit  m_to;

  pong_frame_ctrl #(.X_MAX(X_MAX), .Y_MAX(Y_MAX), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .upd_req(upd_req), .vblank(vblank),
    .bx_in(bx_in), .by_in(by_in), .p1x_in(p1x_in), .p1y_in(p1y_in),
    .p2x_in(p2x_in), .p2y_in(p2y_in), .busy(busy),
    .bx(bx), .by(by), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
    .commit(commit), .timeout(timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".bx"},  32'(bx),  32'(m_sh[0]));
    check({tag, ".by"},  32'(by),  32'(m_sh[1]));
    check({tag, ".p1x"}, 32'(p1x), 32'(m_sh[2]));
    check({tag, ".p1y"}, 32'(p1y), 32'(m_sh[3]));
    check({tag, ".p2x"}, 32'(p2x), 32'(m_sh[4]));
    check({tag, ".p2y"}, 32'(p2y), 32'(m_sh[5]));
    check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_fc));
    check({tag, ".timeout"},   32'(timeout),   32'(m_to));
  endtask

  task automatic model_reset();
    foreach (m_sh[i]) m_sh[i] = 0;
    m_fc = 0;
    m_to = 0;
  endtask

  task automatic drive_in(input int c[6]);
    bx_in  = 10'(c[0]); by_in  = 10'(c[1]);
    p1x_in = 10'(c[2]); p1y_in = 10'(c[3]);
    p2x_in = 10'(c[4]); p2y_in = 10'(c[5]);
  endtask

  // vb_at: WAIT_VB edge (1 = first) at which vblank is presented; 0 = never.
  // hold: extra cycles upd_req stays high after commit; scramble: change inputs after capture.
  task automatic do_update(input string tag, input int c[6], input int vb_at,
                           input int hold, input bit scramble);
    int  ce;
    bit  forced;
    int  junk[6];
    forced = !(vb_at >= 1 && vb_at <= TO);
    ce     = forced ? TO : vb_at;
    drive_in(c);
    upd_req = 1'b1;
    vblank  = 1'b0;
    tick();
    check({tag, ".busy_capture"},    32'(busy),    1);
    check({tag, ".commit_capture"},  32'(commit),  0);
    check({tag, ".timeout_capture"}, 32'(timeout), 0);
    m_to = 0;
    if (scramble) begin
      foreach (junk[i]) junk[i] = int'($urandom_range(0, 1023));
      drive_in(junk);
    end
    for (int k = 1; k <= ce; k++) begin
      vblank = (k == vb_at);
      tick();
      vblank = 1'b0;
      if (k < ce) begin
        check({tag, ".busy_wait"},   32'(busy),   1);
        check({tag, ".commit_wait"}, 32'(commit), 0);
        check({tag, ".bx_wait"},     32'(bx),     32'(m_sh[0]));
      end else begin
        for (int i = 0; i < 6; i++)
          m_sh[i] = (c[i] > ((i % 2 == 0) ? X_MAX : Y_MAX)) ? ((i % 2 == 0) ? X_MAX : Y_MAX) : c[i];
        m_fc = (m_fc + 1) % 256;
        m_to = forced;
        check({tag, ".commit_pulse"}, 32'(commit), 1);
        check({tag, ".busy_commit"},  32'(busy),   1);
        check_state({tag, ".commit"});
      end
    end
    for (int h = 0; h < hold; h++) begin
      vblank = ($urandom_range(0, 1) == 1);
      tick();
      vblank = 1'b0;
      check({tag, ".commit_ack"}, 32'(commit), 0);
      check({tag, ".busy_ack"},   32'(busy),   1);
      check({tag, ".fc_ack"},     32'(frame_cnt), 32'(m_fc));
    end
    upd_req = 1'b0;
    if (hold == 0) begin
      tick();
      check({tag, ".busy_ack0"},   32'(busy),   1);
      check({tag, ".commit_ack0"}, 32'(commit), 0);
    end
    tick();
    check({tag, ".busy_release"}, 32'(busy), 0);
    check_state({tag, ".idle"});
  endtask

  task automatic idle_cycles(input int n);
    upd_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      vblank = ($urandom_range(0, 1) == 1);
      tick();
      vblank = 1'b0;
      check("idle.busy",   32'(busy),   0);
      check("idle.commit", 32'(commit), 0);
      check("idle.fc",     32'(frame_cnt), 32'(m_fc));
      check("idle.timeout", 32'(timeout), 32'(m_to));
    end
  endtask

  initial begin
    int c[6];
    int r[6];
    reset_reset_n = 1'b0;
    upd_req = 1'b0;
    vblank  = 1'b0;
    c = '{0, 0, 0, 0, 0, 0};
    drive_in(c);
    model_reset();
    #12;
    check("reset.busy",   32'(busy),   0);
    check("reset.commit", 32'(commit), 0);
    check_state("reset");
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    tick();

    c = '{100, 200, 10, 50, 600, 70};
    do_update("nominal", c, 5, 2, 0);
    idle_cycles(3);

    c = '{700, 500, 10, 50, 1023, 70};
    do_update("clamp", c, 2, 1, 0);

    c = '{1, 2, 3, 4, 5, 6};
    do_update("watchdog", c, 0, 1, 0);
    idle_cycles(2);
    c = '{7, 8, 9, 10, 11, 12};
    do_update("after_wd", c, 3, 0, 0);
    c = '{639, 479, 640, 480, 0, 1023};
    do_update("coincide", c, TO, 0, 0);
    do_update("first_vb", c, 1, 0, 0);

    idle_cycles(6);
    c = '{321, 123, 45, 67, 89, 101};
    do_update("scramble", c, 4, 3, 1);

    for (int t = 0; t < 40; t++) begin
      foreach (r[i]) r[i] = int'($urandom_range(0, 1023));
      do_update("rand", r, int'($urandom_range(0, TO + 2)), int'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    c = '{300, 10, 20, 30, 40, 50};
    drive_in(c);
    upd_req = 1'b1;
    tick();
    tick();
    tick();
    check("rst_mid.busy_before", 32'(busy), 1);
    #2;
    reset_reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid.busy", 32'(busy), 0);
    check_state("rst_mid");
    upd_req = 1'b0;
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    tick();
    check("rst_mid.busy_after", 32'(busy), 0);
    check_state("rst_mid_after");

    for (int t = 0; t < 256; t++) begin
      c = '{t, t, t, t, t, t};
      do_update("wrap", c, 1, 0, 0);
    end
    check("wrap.frame_cnt_zero", 32'(frame_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
